// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB slave bank.
// Holds the FSM state encoding, byte-lane sizing and a one-hot test.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  // Number of paddr LSBs that select a byte within one data word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic logic is_onehot(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// One slave's register file: DEPTH words of DATA_W bits.
// Asynchronously cleared, single write port, combinational read port.
module apb_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_bank.sv
// Bank of NUM_SLV APB slaves behind the AHB-to-APB bridge, each with a
// register file, programmable wait states and an error response.
module apb_slave_bank
  import apb_pkg::*;
#(
  parameter int NUM_SLV  = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic                            hclk,
  input  logic                            hreset,
  input  logic [NUM_SLV-1:0]              pselx,
  input  logic                            penable,
  input  logic                            pwrite,
  input  logic [ADDR_W-1:0]               paddr,
  input  logic [DATA_W-1:0]               pwdata,
  input  logic [$clog2(MAX_WAIT+1)-1:0]   wait_cfg,
  output logic [DATA_W-1:0]               prdata,
  output logic                            pready,
  output logic                            pslverr,
  output logic                            busy
);

  localparam int LSB   = lane_bits(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SLV_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  apb_state_t state, state_nx;

  logic [CNT_W-1:0]  cnt;
  logic [SLV_W-1:0]  slv_q, slv_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q, err_q, err_d;
  logic              misalign, hi_bad, done, commit;
  logic [DATA_W-1:0] rd_word [NUM_SLV];
  logic [DATA_W-1:0] rd_sel;

  if (LSB == 0) begin : g_nolane
    assign misalign = 1'b0;
  end else begin : g_lane
    assign misalign = |paddr[LSB-1:0];
  end

  // Any address bit above the word index means the word is outside the file.
  assign hi_bad = |(paddr >> (LSB + IDX_W));
  assign err_d  = !is_onehot(64'(pselx)) | misalign | hi_bad;

  always_comb begin
    slv_d = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (pselx[i]) slv_d = SLV_W'(i);
    end
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:   if (|pselx && !penable) state_nx = SETUP;
      SETUP:  state_nx = ACCESS;
      ACCESS: begin
        if (cnt == '0) begin
          done     = 1'b1;
          state_nx = (|pselx && !penable) ? SETUP : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The transfer is captured once in SETUP so later bus changes cannot disturb it.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state   <= IDLE;
      cnt     <= '0;
      slv_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == SETUP) begin
        slv_q   <= slv_d;
        idx_q   <= paddr[LSB +: IDX_W];
        wdata_q <= pwdata;
        wr_q    <= pwrite;
        err_q   <= err_d;
        cnt     <= (wait_cfg > MAX_CNT) ? MAX_CNT : wait_cfg;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign commit = done & wr_q & !err_q;

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_slv
    apb_regfile #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_rf (
      .clk   (hclk),
      .rst   (hreset),
      .we    (commit && (slv_q == SLV_W'(g))),
      .widx  (idx_q),
      .wdata (wdata_q),
      .ridx  (idx_q),
      .rdata (rd_word[g])
    );
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (slv_q == SLV_W'(i)) rd_sel = rd_word[i];
    end
  end

  assign pready  = done;
  assign pslverr = done & err_q;
  assign prdata  = (done && !err_q && !wr_q) ? rd_sel : '0;
  assign busy    = (state != IDLE);

endmodule
